// File: rtl/x_dl_sampler_if.sv
// Frame byte stream from x_dl_sampler to x_uart_tx or x_driver's tx mux.
// Signals: o_valid (byte available), o_data (frame byte), i_accept (sink takes byte).
// Names keep the sampler's point of view; the master modport is the sampler side.
interface x_dl_sampler_if;
  logic       o_valid;
  logic [7:0] o_data;
  logic       i_accept;

  modport master (output o_valid, output o_data, input  i_accept);
  modport slave  (input  o_valid, input  o_data, output i_accept);
endinterface

// File: rtl/x_dl_sampler.sv
// Samples a thermometer code for P_SAMPLES cycles, reduces it to popcount min/max/sum
// plus a bubble count, and streams a 6-byte frame: P_HDR, min, max, sum_hi, sum_lo, bub.
// Latency: first frame byte valid 1 + P_SAMPLES cycles after start; bytes held while i_accept is low.
// Ports: i_clk, i_rst_n (sync, active low), i_start, i_dl[31:0], o_busy; fr = frame stream (master).
module x_dl_sampler #(
  parameter int         P_SAMPLES = 256,
  parameter logic [7:0] P_HDR     = 8'hA5
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [31:0]          i_dl,
  output logic                 o_busy,
  x_dl_sampler_if.master       fr
);

  localparam int CW = $clog2(P_SAMPLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SAMPLE = 2'd1,
    S_SEND   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [7:0]      min_q, max_q, bub_q;
  logic [15:0]     sum_q;
  logic [2:0]      idx_q;

  logic [5:0]      pc;
  logic            bubble;
  logic            last_sample;
  logic            last_byte;
  logic            take;

  function automatic logic [5:0] popcnt(input logic [31:0] v);
    logic [5:0] p;
    p = 6'd0;
    for (int i = 0; i < 32; i++) begin
      p = p + {5'd0, v[i]};
    end
    return p;
  endfunction

  always_comb begin
    pc          = popcnt(i_dl);
    // Adding 1 carries through the low run of ones; any surviving overlap means
    // a one sits above a zero, i.e. the code is not a clean thermometer.
    bubble      = (i_dl & (i_dl + 32'd1)) != 32'd0;
    last_sample = (cnt_q == CW'(P_SAMPLES - 1));
    last_byte   = (idx_q == 3'd5);
    take        = fr.o_valid & fr.i_accept;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (i_start)           state_d = S_SAMPLE;
      S_SAMPLE: if (last_sample)       state_d = S_SEND;
      S_SEND:   if (take && last_byte) state_d = S_IDLE;
      default:                         state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      min_q   <= 8'd0;
      max_q   <= 8'd0;
      sum_q   <= 16'd0;
      bub_q   <= 8'd0;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            cnt_q <= '0;
            min_q <= 8'hFF;
            max_q <= 8'd0;
            sum_q <= 16'd0;
            bub_q <= 8'd0;
          end
        end
        S_SAMPLE: begin
          cnt_q <= cnt_q + 1'b1;
          if ({2'b00, pc} < min_q) min_q <= {2'b00, pc};
          if ({2'b00, pc} > max_q) max_q <= {2'b00, pc};
          sum_q <= sum_q + {10'd0, pc};
          if (bubble && bub_q != 8'hFF) bub_q <= bub_q + 8'd1;
          if (last_sample) idx_q <= 3'd0;
        end
        S_SEND: begin
          if (take) idx_q <= idx_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded from registered state, so o_data only moves on an accept.
  always_comb begin
    o_busy     = (state_q != S_IDLE);
    fr.o_valid = (state_q == S_SEND);
    fr.o_data  = 8'd0;
    if (state_q == S_SEND) begin
      case (idx_q)
        3'd0:    fr.o_data = P_HDR;
        3'd1:    fr.o_data = min_q;
        3'd2:    fr.o_data = max_q;
        3'd3:    fr.o_data = sum_q[15:8];
        3'd4:    fr.o_data = sum_q[7:0];
        3'd5:    fr.o_data = bub_q;
        default: fr.o_data = 8'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_x_dl_sampler.sv
// Randomised and directed runs of x_dl_sampler (P_SAMPLES=4) against a frame model.
// Checks reset, latency, frame contents, backpressure hold, ignored starts and mid-frame reset.
// Summary line reports passed/total checks.
module tb_x_dl_sampler;
  localparam int P = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic [31:0] i_dl;
  logic        o_busy;

  x_dl_sampler_if fr ();

  x_dl_sampler #(.P_SAMPLES(P), .P_HDR(8'hA5)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (i_start),
    .i_dl    (i_dl),
    .o_busy  (o_busy),
    .fr      (fr.master)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Reference: frame built straight from the definitions of each field.
  typedef logic [7:0] frame_t [6];

  function automatic frame_t model(input logic [31:0] codes [P]);
    frame_t f;
    int mn, mx, sm, bb, c;
    logic [32:0] therm;
    mn = 255; mx = 0; sm = 0; bb = 0;
    for (int k = 0; k < P; k++) begin
      c = $countones(codes[k]);
      if (c < mn) mn = c;
      if (c > mx) mx = c;
      sm += c;
      therm = (33'd1 << c) - 33'd1;   // the only clean code with c ones
      if ({1'b0, codes[k]} != therm && bb < 255) bb++;
    end
    f[0] = 8'hA5;
    f[1] = mn[7:0];
    f[2] = mx[7:0];
    f[3] = sm[15:8];
    f[4] = sm[7:0];
    f[5] = bb[7:0];
    return f;
  endfunction

  // One run: start, P samples, receive frame.
  // stall2: hold accept low 10 cycles on byte 2; rnd_acc: random accept gaps;
  // poke: pulse start during SAMPLE and SEND; abort_at: reset when that byte is on the bus (-1 = never).
  task automatic run(input logic [31:0] codes [P], input bit stall2, input bit rnd_acc,
                     input bit poke, input int abort_at, input string nm);
    frame_t exp;
    int got, stall_left;
    bit acc;
    exp = model(codes);
    got = 0;
    stall_left = stall2 ? 10 : 0;

    @(negedge i_clk);
    i_start  = 1'b1;
    fr.i_accept = 1'b0;
    @(posedge i_clk);                 // start edge
    for (int k = 0; k < P; k++) begin
      @(negedge i_clk);
      i_dl    = codes[k];
      i_start = poke && (k == 1);
      chk({nm, "_nvalid_sample"}, {31'd0, fr.o_valid}, 32'd0);
      chk({nm, "_busy_sample"},   {31'd0, o_busy},     32'd1);
      @(posedge i_clk);
    end
    @(negedge i_clk);
    i_start = 1'b0;
    i_dl    = $urandom;
    // first valid exactly 1 + P edges counting the start edge
    chk({nm, "_latency_valid"}, {31'd0, fr.o_valid}, 32'd1);

    for (int cyc = 0; cyc < 200 && got < 6; cyc++) begin
      if (abort_at >= 0 && got == abort_at) begin
        i_rst_n = 1'b0;
        fr.i_accept = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        chk({nm, "_abort_valid"}, {31'd0, fr.o_valid}, 32'd0);
        chk({nm, "_abort_busy"},  {31'd0, o_busy},     32'd0);
        chk({nm, "_abort_data"},  {24'd0, fr.o_data},  32'd0);
        i_rst_n = 1'b1;
        return;
      end
      if (got == 2 && stall_left > 0) begin
        acc = 1'b0;
        stall_left--;
        chk({nm, "_stall_hold"}, {24'd0, fr.o_data}, {24'd0, exp[2]});
      end else if (rnd_acc) begin
        acc = ($urandom_range(0, 3) != 0);
      end else begin
        acc = 1'b1;
      end
      fr.i_accept = acc;
      i_start = poke && (got == 1 || got == 5);
      chk({nm, "_valid_send"}, {31'd0, fr.o_valid}, 32'd1);
      if (fr.o_valid && acc) begin
        chk($sformatf("%s_byte%0d", nm, got), {24'd0, fr.o_data}, {24'd0, exp[got]});
        got++;
      end
      @(posedge i_clk);
      @(negedge i_clk);
    end
    i_start = 1'b0;
    fr.i_accept = 1'b0;
    chk({nm, "_bytes_delivered"}, got, 6);
    chk({nm, "_idle_valid"}, {31'd0, fr.o_valid}, 32'd0);
    chk({nm, "_idle_busy"},  {31'd0, o_busy},     32'd0);
  endtask

  function automatic logic [31:0] rnd_code();
    logic [32:0] t;
    if ($urandom_range(0, 1) == 0) begin
      t = (33'd1 << $urandom_range(0, 32)) - 33'd1;
      return t[31:0];
    end
    return $urandom;
  endfunction

  logic [31:0] c [P];

  initial begin
    i_rst_n = 1'b0;
    i_start = 1'b1;
    i_dl    = 32'd0;
    fr.i_accept = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      chk("rst_valid", {31'd0, fr.o_valid}, 32'd0);
      chk("rst_data",  {24'd0, fr.o_data},  32'd0);
      chk("rst_busy",  {31'd0, o_busy},     32'd0);
    end
    i_rst_n = 1'b1;
    i_start = 1'b0;

    c = '{32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF};
    run(c, 1'b0, 1'b0, 1'b0, -1, "const16");
    c = '{32'h1, 32'hFFFFFFFF, 32'h0, 32'h7};
    run(c, 1'b0, 1'b0, 1'b0, -1, "extremes");
    c = '{32'h5, 32'h5, 32'hF0, 32'h1};
    run(c, 1'b0, 1'b0, 1'b0, -1, "bubbles");
    c = '{32'h3, 32'h3F, 32'hFF, 32'h1F};
    run(c, 1'b1, 1'b0, 1'b0, -1, "stall");
    c = '{32'h1, 32'h9, 32'h7, 32'hF};
    run(c, 1'b0, 1'b0, 1'b1, -1, "poke");
    c = '{32'h7, 32'h8000_0000, 32'hF, 32'h1};
    run(c, 1'b0, 1'b0, 1'b0, 3, "abort");
    c = '{32'hFF, 32'h3, 32'h1_0000, 32'h7FFF};
    run(c, 1'b0, 1'b0, 1'b0, -1, "fresh");

    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < P; k++) c[k] = rnd_code();
      run(c, 1'b0, 1'b1, ($urandom_range(0, 1) == 1), -1, $sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
